// File: rtl/writeback_stage.sv
// ============================================================================
// Module  : writeback_stage
// Brief   : MEM/WB stage feeding the register file, with load wait/timeout,
//           decode bypass and load-use hazard detection. Optional retire
//           counter enabled by defining WB_RETIRE_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef REG0
`define REG0 4'd0
`endif
`ifndef T
`define T 4'd14
`endif
`ifndef PC
`define PC 4'd15
`endif

module writeback_stage #(
    parameter int WIDTH       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic             InRegWre,
    input  logic [3:0]       InWriteReg,
    input  logic [1:0]       InWbSel,
    input  logic [WIDTH-1:0] InAluResult,
    input  logic [WIDTH-1:0] InPcNext,
    input  logic             Flush,
    input  logic             MemDone,
    input  logic [WIDTH-1:0] MemData,
    output logic             RegWre,
    output logic [3:0]       WriteReg,
    output logic [WIDTH-1:0] WriteData,
    input  logic [3:0]       FwdRs,
    input  logic [3:0]       FwdRt,
    output logic             FwdHit1,
    output logic             FwdHit2,
    output logic [WIDTH-1:0] FwdData1,
    output logic [WIDTH-1:0] FwdData2,
    output logic             LoadHazard,
    output logic             MemErr,
    output logic [15:0]      RetireCount
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        LOAD_WAIT = 2'd1,
        FULL      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t           state;
    logic             held_regwre;
    logic [3:0]       held_reg;
    logic [WIDTH-1:0] held_data;
    logic [7:0]       wait_cnt;
    logic             mem_err;
    logic             accept;
    logic             fwd_ok;
    logic [WIDTH-1:0] fwd_value;

    assign InReady = (state != LOAD_WAIT);
    assign accept  = InValid & InReady & ~Flush;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= EMPTY;
            held_regwre <= 1'b0;
            held_reg    <= 4'd0;
            held_data   <= '0;
            wait_cnt    <= 8'd0;
            mem_err     <= 1'b0;
        end else begin
            case (state)
                LOAD_WAIT: begin
                    // MemDone wins over a timeout landing on the same edge
                    if (MemDone) begin
                        state     <= FULL;
                        held_data <= MemData;
                    end else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                        state       <= EMPTY;
                        held_regwre <= 1'b0;
                        wait_cnt    <= 8'd0;
                        mem_err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        held_regwre <= InRegWre;
                        held_reg    <= InWriteReg;
                        if (InWbSel == 2'd1) begin
                            state    <= LOAD_WAIT;
                            wait_cnt <= 8'd0;
                        end else begin
                            state     <= FULL;
                            held_data <= (InWbSel == 2'd2) ? InPcNext : InAluResult;
                        end
                    end else begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign RegWre    = (state == FULL) & held_regwre;
    assign WriteReg  = held_reg;
    assign WriteData = held_data;
    assign MemErr    = mem_err;

    // T reads back as a boolean in the register file, so bypass must match
    assign fwd_ok    = RegWre & (held_reg != `REG0) & (held_reg != `PC);
    assign fwd_value = (held_reg == `T) ? {{(WIDTH-1){1'b0}}, |held_data} : held_data;

    assign FwdHit1  = fwd_ok & (FwdRs == held_reg);
    assign FwdHit2  = fwd_ok & (FwdRt == held_reg);
    assign FwdData1 = FwdHit1 ? fwd_value : '0;
    assign FwdData2 = FwdHit2 ? fwd_value : '0;

    assign LoadHazard = (state == LOAD_WAIT) & held_regwre & (held_reg != `REG0) &
                        ((FwdRs == held_reg) | (FwdRt == held_reg));

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] retire_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            retire_cnt <= 16'd0;
        end else if (state == FULL) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign RetireCount = retire_cnt;
`else
    assign RetireCount = 16'd0;
`endif

endmodule

`default_nettype wire
